universal_counter_register: RTL and testbench

Parametrised successor to the team's plain D register. It is a WIDTH-bit register with an operation select:
- hold
- parallel load
- modulo up/down count
- shift left/right with serial input
- rotate
- synchronous clear

It has a configurable modulus, a choice of wrap or saturate overflow handling, and a registered overflow pulse. It is the building block for the counters under prac/counter: BCD digits, event counters and shift chains.

---
 rtl/universal_counter_register_if.sv | 23 ++
 rtl/universal_counter_register.sv | 91 +++++++++
 tb/tb_universal_counter_register.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/universal_counter_register_if.sv
// universal_counter_register_if: control/data bundle for the counter register.
// master drives en/op/d/sin and reads q/wrap/tc; slave is the register side.
interface universal_counter_register_if #(
  parameter int WIDTH = 7
);
  logic             en;
  logic [2:0]       op;
  logic [WIDTH-1:0] d;
  logic             sin;
  logic [WIDTH-1:0] q;
  logic             wrap;
  logic             tc;

  modport master (
    output en, op, d, sin,
    input  q, wrap, tc
  );

  modport slave (
    input  en, op, d, sin,
    output q, wrap, tc
  );
endinterface

// File: rtl/universal_counter_register.sv
// universal_counter_register: WIDTH-bit register with hold/load/count/shift/rotate/clear.
// Ports: clk, reset (async active-low), bus (en,op,d,sin in; q,wrap,tc out).
module universal_counter_register #(
  parameter int WIDTH       = 7,
  parameter int MAX_COUNT   = 2**WIDTH-1,
  parameter bit SATURATE    = 1'b0,
  parameter int RESET_VALUE = 0
) (
  input logic clk,
  input logic reset,
  universal_counter_register_if.slave bus
);

  localparam logic [2:0] OP_HOLD  = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_UP    = 3'b010;
  localparam logic [2:0] OP_DOWN  = 3'b011;
  localparam logic [2:0] OP_SHL   = 3'b100;
  localparam logic [2:0] OP_SHR   = 3'b101;
  localparam logic [2:0] OP_ROL   = 3'b110;
  localparam logic [2:0] OP_CLEAR = 3'b111;

  // One extra bit so MAX_COUNT = 2**WIDTH-1 compares/increments cleanly.
  localparam logic [WIDTH:0]   MAXV = (WIDTH+1)'(MAX_COUNT);
  localparam logic [WIDTH-1:0] MAXQ = MAXV[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RSTV = WIDTH'(RESET_VALUE);

  logic [WIDTH-1:0] q;
  logic             wrap;
  logic [WIDTH:0]   qx;
  logic [WIDTH:0]   res;
  logic [WIDTH-1:0] q_nxt;
  logic             wrap_nxt;

  function automatic logic [WIDTH-1:0] clamp(
    input logic [WIDTH:0] v
  );
    return (v > MAXV) ? MAXQ : v[WIDTH-1:0];
  endfunction

  assign qx = {1'b0, q};

  always_comb begin
    res      = qx;
    wrap_nxt = 1'b0;
    if (bus.en) begin
      unique case (bus.op)
        OP_HOLD:  res = qx;
        OP_LOAD:  res = {1'b0, bus.d};
        OP_UP: begin
          if (qx == MAXV) begin
            res      = SATURATE ? MAXV : '0;
            wrap_nxt = 1'b1;
          end else begin
            res = qx + 1'b1;
          end
        end
        OP_DOWN: begin
          if (qx == '0) begin
            res      = SATURATE ? '0 : MAXV;
            wrap_nxt = 1'b1;
          end else begin
            res = qx - 1'b1;
          end
        end
        OP_SHL:   res = {1'b0, q[WIDTH-2:0], bus.sin};
        OP_SHR:   res = {1'b0, bus.sin, q[WIDTH-1:1]};
        OP_ROL:   res = {1'b0, q[WIDTH-2:0], q[WIDTH-1]};
        OP_CLEAR: res = {1'b0, RSTV};
        default:  res = qx;
      endcase
    end
    // Loads and shifts can land above the modulus; pin them to the limit.
    q_nxt = clamp(res);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q    <= RSTV;
      wrap <= 1'b0;
    end else begin
      q    <= q_nxt;
      wrap <= wrap_nxt;
    end
  end

  assign bus.q    = q;
  assign bus.wrap = wrap;
  assign bus.tc   = (qx == MAXV);

endmodule

// File: tb/tb_universal_counter_register.sv
// tb_universal_counter_register: scoreboard bench over default, BCD and saturate configs.
// Stimulus pushes expectations; a monitor pops and compares after each rising edge.
module tb_universal_counter_register;

  localparam logic [2:0] HOLD  = 3'b000;
  localparam logic [2:0] LOAD  = 3'b001;
  localparam logic [2:0] UP    = 3'b010;
  localparam logic [2:0] DOWN  = 3'b011;
  localparam logic [2:0] SHL   = 3'b100;
  localparam logic [2:0] SHR   = 3'b101;
  localparam logic [2:0] ROL   = 3'b110;
  localparam logic [2:0] CLEAR = 3'b111;

  typedef struct {
    int         dut;
    logic [6:0] q;
    logic       w;
    logic       tc;
    string      nm;
  } exp_t;

  logic clk;
  logic rst;
  int   n_run;
  int   n_fail;
  exp_t sb[$];

  universal_counter_register_if #(.WIDTH(7)) if0 ();
  universal_counter_register_if #(.WIDTH(7)) if1 ();
  universal_counter_register_if #(.WIDTH(7)) if2 ();

  universal_counter_register #(.WIDTH(7)) u_def (
    .clk   (clk),
    .reset (rst),
    .bus   (if0)
  );

  universal_counter_register #(
    .WIDTH(7), .MAX_COUNT(9), .SATURATE(1'b0)
  ) u_bcd (
    .clk   (clk),
    .reset (rst),
    .bus   (if1)
  );

  universal_counter_register #(
    .WIDTH(7), .MAX_COUNT(9), .SATURATE(1'b1)
  ) u_sat (
    .clk   (clk),
    .reset (rst),
    .bus   (if2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(
    input int dut, input string nm,
    input logic [6:0] eq, input logic ew, input logic et
  );
    logic [6:0] aq;
    logic       aw;
    logic       at;
    case (dut)
      0:       begin aq = if0.q; aw = if0.wrap; at = if0.tc; end
      1:       begin aq = if1.q; aw = if1.wrap; at = if1.tc; end
      default: begin aq = if2.q; aw = if2.wrap; at = if2.tc; end
    endcase
    n_run++;
    if (aq !== eq || aw !== ew || at !== et) begin
      n_fail++;
      $display("FAIL %s: got q=%0d wrap=%b tc=%b, want q=%0d wrap=%b tc=%b",
               nm, aq, aw, at, eq, ew, et);
    end
  endtask

  task automatic drive(
    input int dut, input logic e, input logic [2:0] o,
    input logic [6:0] dv, input logic s
  );
    if0.en = 1'b0; if1.en = 1'b0; if2.en = 1'b0;
    case (dut)
      0: begin if0.en = e; if0.op = o; if0.d = dv; if0.sin = s; end
      1: begin if1.en = e; if1.op = o; if1.d = dv; if1.sin = s; end
      default: begin if2.en = e; if2.op = o; if2.d = dv; if2.sin = s; end
    endcase
  endtask

  task automatic step(
    input int dut, input logic e, input logic [2:0] o,
    input logic [6:0] dv, input logic s,
    input logic [6:0] eq, input logic ew, input logic et,
    input string nm
  );
    @(negedge clk);
    drive(dut, e, o, dv, s);
    sb.push_back('{dut, eq, ew, et, nm});
  endtask

  // Monitor: every output update is checked against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        cmp(e.dut, e.nm, e.q, e.w, e.tc);
      end
    end
  end

  initial begin
    n_run  = 0;
    n_fail = 0;
    rst    = 1'b0;
    if0.op = HOLD; if0.d = '0; if0.sin = 1'b0;
    if1.op = HOLD; if1.d = '0; if1.sin = 1'b0;
    if2.op = HOLD; if2.d = '0; if2.sin = 1'b0;
    drive(0, 1'b1, LOAD, 7'd1, 1'b0);

    // Reset held with a pending LOAD: q stays at 0 across edges.
    #3 cmp(0, "rst_t3", 7'd0, 1'b0, 1'b0);
    @(posedge clk); #1 cmp(0, "rst_edge1", 7'd0, 1'b0, 1'b0);
    @(posedge clk); #1 cmp(0, "rst_edge2", 7'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    sb.push_back('{0, 7'd1, 1'b0, 1'b0, "rst_release_load"});

    // Up wrap, default config.
    step(0, 1, LOAD, 7'd126, 0, 7'd126, 0, 0, "load126");
    step(0, 1, UP,   7'd0,   0, 7'd127, 0, 1, "up127");
    step(0, 1, UP,   7'd0,   0, 7'd0,   1, 0, "up_wrap0");
    step(0, 1, UP,   7'd0,   0, 7'd1,   0, 0, "up1");

    // Shift and rotate.
    step(0, 1, LOAD,  7'b1000001, 0, 7'b1000001, 0, 0, "load65");
    step(0, 1, SHL,   7'd0, 1, 7'b0000011, 0, 0, "shl");
    step(0, 1, ROL,   7'd0, 0, 7'b0000110, 0, 0, "rol");
    step(0, 1, SHR,   7'd0, 1, 7'b1000011, 0, 0, "shr");
    step(0, 1, CLEAR, 7'd0, 0, 7'd0,       0, 0, "clear");

    // Enable gating.
    step(0, 1, LOAD, 7'd50, 0, 7'd50, 0, 0, "load50");
    for (int i = 0; i < 3; i++)
      step(0, 0, UP, 7'd0, 0, 7'd50, 0, 0, "en0_up");
    step(0, 1, UP,   7'd0,   0, 7'd51,  0, 0, "en1_up51");
    step(0, 1, LOAD, 7'd127, 0, 7'd127, 0, 1, "load127");
    step(0, 1, UP,   7'd0,   0, 7'd0,   1, 0, "wrap_again");
    step(0, 0, UP,   7'd0,   0, 7'd0,   0, 0, "en0_clears_wrap");

    // BCD config.
    step(1, 1, DOWN, 7'd0,  0, 7'd9, 1, 1, "bcd_down_wrap");
    step(1, 1, LOAD, 7'd15, 0, 7'd9, 0, 1, "bcd_load_clamp");
    step(1, 1, SHL,  7'd0,  1, 7'd9, 0, 1, "bcd_shl_clamp");
    step(1, 1, CLEAR, 7'd0, 0, 7'd0, 0, 0, "bcd_clear");
    for (int i = 1; i <= 10; i++)
      step(1, 1, UP, 7'd0, 0, 7'(i % 10), (i == 10), (i == 9), "bcd_up");
    step(1, 1, HOLD, 7'd0, 0, 7'd0, 0, 0, "bcd_hold");

    // Saturate config.
    step(2, 1, LOAD, 7'd9, 0, 7'd9, 0, 1, "sat_load9");
    step(2, 1, UP,   7'd0, 0, 7'd9, 1, 1, "sat_up1");
    step(2, 1, UP,   7'd0, 0, 7'd9, 1, 1, "sat_up2");
    step(2, 1, DOWN, 7'd0, 0, 7'd8, 0, 0, "sat_down8");
    step(2, 1, LOAD, 7'd0, 0, 7'd0, 0, 0, "sat_load0");
    step(2, 1, DOWN, 7'd0, 0, 7'd0, 1, 0, "sat_down_blk1");
    step(2, 1, DOWN, 7'd0, 0, 7'd0, 1, 0, "sat_down_blk2");

    // Async reset mid-cycle during an UP sequence.
    step(0, 1, LOAD, 7'd50, 0, 7'd50, 0, 0, "pre_rst_load50");
    @(negedge clk);
    drive(0, 1'b1, UP, 7'd0, 1'b0);
    #2 rst = 1'b0;
    #1 cmp(0, "async_rst_now", 7'd0, 1'b0, 1'b0);
    @(posedge clk); #1 cmp(0, "async_rst_edge", 7'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    sb.push_back('{0, 7'd1, 1'b0, 1'b0, "post_rst_up"});

    repeat (2) @(posedge clk);
    #3;
    n_run++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
